// File: rtl/tmds_channel_decoder.sv
// Purpose: recover symbol alignment on one TMDS channel and decode each aligned symbol to data/control.
// Latency: 2 cycles from the word pair that forms a symbol to de/data/ctrl; locked rises with the outputs of the run-completing token.
// Backpressure: none; one raw word is consumed every cycle and the outputs are not stallable.
module tmds_channel_decoder #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk_25mhz,
  input  logic       resetn,
  input  logic [9:0] raw,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int WMAX   = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int WCNT_W = $clog2(WMAX + 1);
  localparam int RUN_W  = $clog2(CTRL_RUN + 1);

  localparam logic [WCNT_W-1:0] SEARCH_LAST = WCNT_W'(SEARCH_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] LOSS_LAST   = WCNT_W'(LOSS_TIMEOUT - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST    = RUN_W'(CTRL_RUN - 1);
  localparam logic [RUN_W-1:0]  RUN_FULL    = RUN_W'(CTRL_RUN);

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t            state_q, state_d;
  logic [9:0]        prev_q;
  logic [9:0]        q_r;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [3:0]        offset_q, offset_d;
  logic              de_r;
  logic [7:0]        data_r;
  logic [1:0]        ctrl_r;

  logic [19:0]       comb;
  logic [9:0]        aligned;
  logic              q_tok;
  logic [1:0]        q_tok_val;
  logic [7:0]        q_qm;
  logic [7:0]        q_dec;

  // Select the 10-bit window at the current bit offset from the last two raw words
  always_comb begin
    comb    = {raw, prev_q};
    aligned = 10'(comb >> offset_q);
  end

  // Capture the previous raw word and the aligned symbol
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      prev_q <= '0;
      q_r    <= '0;
    end else begin
      prev_q <= raw;
      q_r    <= aligned;
    end
  end

  // Recognise the four control tokens in the aligned symbol
  always_comb begin
    q_tok     = 1'b1;
    q_tok_val = 2'b00;
    case (q_r)
      10'h354: q_tok_val = 2'b00;
      10'h0AB: q_tok_val = 2'b01;
      10'h154: q_tok_val = 2'b10;
      10'h2AB: q_tok_val = 2'b11;
      default: q_tok     = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain
  always_comb begin
    q_qm     = q_r[9] ? ~q_r[7:0] : q_r[7:0];
    q_dec    = '0;
    q_dec[0] = q_qm[0];
    for (int i = 1; i < 8; i++) begin
      q_dec[i] = q_r[8] ? (q_qm[i] ^ q_qm[i-1]) : ~(q_qm[i] ^ q_qm[i-1]);
    end
  end

  // Output stage runs unconditionally; lock gating is applied at the ports
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      de_r   <= 1'b0;
      data_r <= '0;
      ctrl_r <= '0;
    end else if (q_tok) begin
      de_r   <= 1'b0;
      data_r <= '0;
      ctrl_r <= q_tok_val;
    end else begin
      de_r   <= 1'b1;
      data_r <= q_dec;
    end
  end

  // Alignment FSM state and counters
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_SEARCH;
      run_q    <= '0;
      wcnt_q   <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      wcnt_q   <= wcnt_d;
      offset_q <= offset_d;
    end
  end

  // Next-state: lock on a full token run, step the offset on search or loss timeout
  always_comb begin
    logic [RUN_W-1:0]  run_inc;
    logic [WCNT_W-1:0] wcnt_inc;
    logic [3:0]        offset_nxt;
    logic              run_hit;

    state_d    = state_q;
    run_d      = run_q;
    wcnt_d     = wcnt_q;
    offset_d   = offset_q;
    run_inc    = (run_q == RUN_FULL) ? run_q : run_q + RUN_W'(1);
    wcnt_inc   = (wcnt_q == '1) ? wcnt_q : wcnt_q + WCNT_W'(1);
    offset_nxt = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    run_hit    = q_tok && (run_q == RUN_LAST);

    run_d  = q_tok ? run_inc : '0;
    wcnt_d = wcnt_inc;

    case (state_q)
      ST_SEARCH: begin
        if (run_hit) begin
          state_d = ST_LOCKED;
          run_d   = '0;
          wcnt_d  = '0;
        end else if (wcnt_q == SEARCH_LAST) begin
          offset_d = offset_nxt;
          run_d    = '0;
          wcnt_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (run_hit) begin
          wcnt_d = '0;
        end else if (wcnt_q == LOSS_LAST) begin
          state_d  = ST_SEARCH;
          offset_d = offset_nxt;
          run_d    = '0;
          wcnt_d   = '0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Gate the output stage with the registered lock so in-flight words vanish on loss
  always_comb begin
    locked = (state_q == ST_LOCKED);
    de     = locked & de_r;
    data   = locked ? data_r : 8'h00;
    ctrl   = locked ? ctrl_r : 2'b00;
    offset = offset_q;
  end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side counterpart of the HDMI/DVI TMDS transmit path. It takes 10-bit raw words from one TMDS channel deserializer, which may sit at an arbitrary bit offset. It finds symbol alignment from control-token runs during blanking, then decodes each aligned symbol into a data byte, a control pair and a data-enable flag. One instance per channel sits between the deserializer and the receive-side timing/pixel logic.

## Interface

Parameters:
- `CTRL_RUN`, default 8: number of consecutive control tokens needed to declare lock.
- `SEARCH_TIMEOUT`, default 2048: words spent at one offset in SEARCH before the offset advances.
- `LOSS_TIMEOUT`, default 4096: words allowed in LOCKED without a qualifying control run before lock is dropped.

Ports:
- `clk_25mhz`, in, 1: pixel/word clock. All logic runs on the rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `raw`, in, 10: deserializer word. `raw[0]` is the earliest serial bit.
- `de`, out, 1: 1 while the current aligned symbol is a data symbol.
- `data`, out, 8: decoded byte.
- `ctrl`, out, 2: `{C1,C0}` from the most recent control token.
- `locked`, out, 1: alignment achieved.
- `offset`, out, 4: current bit offset, range 0..9.

## Operation

Alignment window:
- `prev` holds `raw` from the previous cycle.
- The concatenation `comb = {raw, prev}` is 20 bits.
- The aligned word is `comb[offset+9:offset]`.
- A stream delayed by k bit times aligns at `offset = k`.

Control tokens, with the value of `{C1,C0}` each one produces:
- 0x354 → 00
- 0x0AB → 01
- 0x154 → 10
- 0x2AB → 11

Data decode of aligned word q:
- `qm = q[9] ? ~q[7:0] : q[7:0]`.
- `d[0] = qm[0]`.
- For i = 1..7: `d[i] = q[8] ? qm[i]^qm[i-1] : ~(qm[i]^qm[i-1])`.

State machine, two states:
- **SEARCH** (reset state):
  - `run` counts consecutive control tokens. A non-token clears it.
  - `wcnt` counts words.
  - `run` reaching `CTRL_RUN` → LOCKED. Clear `wcnt` and `run`.
  - Otherwise, `wcnt` reaching `SEARCH_TIMEOUT-1` → advance `offset` (9 wraps to 0) and clear `wcnt` and `run`.
  - Lock takes priority when both happen in the same cycle.
- **LOCKED**:
  - `wcnt` counts words. Every time `run` reaches `CTRL_RUN`, `wcnt` is cleared.
  - `wcnt` reaching `LOSS_TIMEOUT-1` → SEARCH. Advance `offset` and clear counters.
  - A run completing in the same cycle as the timeout wins; stay LOCKED.
- Counters saturate; they never wrap.

Outputs:
- While `locked=0`: `de=0`, `data=0`, `ctrl=0`.
- While locked, for a token: `de=0`, `data=0`, `ctrl` = token value.
- While locked, for a non-token: `de=1`, `data` = decoded byte, `ctrl` holds its previous value.
- Data validity is not checked. Any non-token word decodes.

## Timing

- Reset value of every output is 0, including `offset=0`. FSM resets to SEARCH. `prev` and all counters clear.
- Latency is 2 cycles. The word assembled from `raw(N)` and `raw(N-1)` drives `de`/`data`/`ctrl` after the edge at N+2.
- `locked` rises on the same edge as the outputs of the `CTRL_RUN`-th token. That token's `ctrl` is already presented.
- An offset change takes effect on the window at the next edge.
- Words already in the pipeline when lock drops are suppressed to 0, because output gating uses the registered `locked`.
- Asserting `resetn` mid-stream clears everything immediately. After release, the search restarts at offset 0.

## Test plan

1. **Reset:** assert `resetn=0` with random `raw` → all outputs 0, `offset=0`. After release with `raw=0`, `locked` stays 0 and `offset` reaches 1 after 2048 cycles.
2. **Aligned lock and decode:** 8× 0x354, then 0x100, then 0x2FF.
   - `locked` = 1 with `ctrl=00` and `de=0` 2 cycles after the 8th token.
   - Then `de=1, data=0x00`, then `de=1, data=0xFE`.
   - `ctrl` stays 00 throughout.
3. **Token decode:** while locked, feed 0x0AB, 0x154, 0x2AB → `ctrl` = 01, 10, 11 on consecutive cycles, `de=0`, `data=0`.
4. **Misaligned stream:** a repeating line of 160 tokens plus 640 data words, delayed by 3 bit times → `offset` steps 0→1→2→3 at 2048-word intervals. Lock occurs at `offset=3` and decoded data matches the source.
5. **Loss of lock:** lock, then 4096 words of 0x100 only → `locked` falls on word 4096, `offset` increments and outputs go to 0. Restoring a token run of 8 at the correct alignment relocks.
6. **Reset mid-lock:** pulse `resetn` low for 1 cycle while locked → all outputs 0 asynchronously. Search restarts at `offset=0`.
